// File: rtl/strb_driver.sv
// Strobe-launched burst driver: bytes queue in a FIFO and are replayed onto DQ_IN
// as a burst of BURST_LEN+1 slots, STRB_DELAY cycles after an accepted STRB pulse.
module strb_driver #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int DLYW  = 5,
  parameter int LENW  = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DW-1:0]            WR_DATA,
  input  logic                     WR_VALID,
  output logic                     WR_READY,
  input  logic                     STRB,
  input  logic [DLYW-1:0]          STRB_DELAY,
  input  logic [LENW-1:0]          BURST_LEN,
  output logic [DW-1:0]            DQ_IN,
  output logic                     DQ_IN_VALID,
  output logic                     BUSY,
  output logic                     STRB_DROP,
  output logic                     UNDERRUN,
  output logic [$clog2(DEPTH):0]   LEVEL
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LVW = AW + 1;
  localparam int SW  = LENW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DRIVE} state_t;

  state_t          state_reg, state_next;
  logic [DLYW-1:0] dly_reg, dly_next;
  logic [SW-1:0]   slot_reg, slot_next;
  logic            fire;

  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LVW-1:0]  count_reg;
  logic            push, pop, empty;

  logic [DW-1:0]   dq_reg;
  logic            dq_valid_reg, strb_drop_reg, underrun_reg;

  assign WR_READY    = (count_reg != LVW'(DEPTH));
  assign empty       = (count_reg == '0);
  assign push        = WR_VALID && WR_READY;
  assign pop         = fire && !empty;

  assign DQ_IN       = dq_reg;
  assign DQ_IN_VALID = dq_valid_reg;
  assign BUSY        = (state_reg != ST_IDLE);
  assign STRB_DROP   = strb_drop_reg;
  assign UNDERRUN    = underrun_reg;
  assign LEVEL       = count_reg;

  // A slot "fires" on the edge that enters its DRIVE cycle, so the registered
  // word is on DQ_IN during that cycle; slot_reg counts slots still to fire.
  always_comb begin
    state_next = state_reg;
    dly_next   = dly_reg;
    slot_next  = slot_reg;
    fire       = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (STRB) begin
          if (STRB_DELAY == '0) begin
            fire       = 1'b1;
            slot_next  = SW'(BURST_LEN);
            state_next = ST_DRIVE;
          end else begin
            dly_next   = STRB_DELAY;
            slot_next  = SW'(BURST_LEN) + SW'(1);
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (dly_reg == DLYW'(1)) begin
          fire       = 1'b1;
          slot_next  = slot_reg - SW'(1);
          state_next = ST_DRIVE;
        end else begin
          dly_next = dly_reg - DLYW'(1);
        end
      end
      ST_DRIVE: begin
        if (slot_reg == '0) begin
          state_next = ST_IDLE;
        end else begin
          fire      = 1'b1;
          slot_next = slot_reg - SW'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_IDLE;
      dly_reg   <= '0;
      slot_reg  <= '0;
    end else begin
      state_reg <= state_next;
      dly_reg   <= dly_next;
      slot_reg  <= slot_next;
    end
  end

  // Storage kept out of reset so it maps onto block RAM.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_reg] <= WR_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LVW'(1);
        2'b01:   count_reg <= count_reg - LVW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Empty slots still consume burst length; they just flag the underrun.
  always_ff @(posedge CLK) begin
    if (RST) begin
      dq_reg        <= '0;
      dq_valid_reg  <= 1'b0;
      strb_drop_reg <= 1'b0;
      underrun_reg  <= 1'b0;
    end else begin
      strb_drop_reg <= STRB && (state_reg != ST_IDLE);
      if (pop) begin
        dq_reg       <= mem[rd_ptr_reg];
        dq_valid_reg <= 1'b1;
      end else begin
        dq_reg       <= '0;
        dq_valid_reg <= 1'b0;
      end
      if (fire && empty) underrun_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_strb_driver.sv
// Randomized bench for strb_driver: a queue-and-schedule reference model predicts
// every output each cycle from accepted strobes, delays and burst lengths.
module tb_strb_driver;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int DLYW  = 5;
  localparam int LENW  = 4;
  localparam int NCYC  = 4000;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [DW-1:0]         wr_data;
  logic                  wr_valid;
  logic                  wr_ready;
  logic                  strb;
  logic [DLYW-1:0]       strb_delay;
  logic [LENW-1:0]       burst_len;
  logic [DW-1:0]         dq_in;
  logic                  dq_in_valid;
  logic                  busy;
  logic                  strb_drop;
  logic                  underrun;
  logic [$clog2(DEPTH):0] level;

  always #5 clk = ~clk;

  strb_driver #(.DW(DW), .DEPTH(DEPTH), .DLYW(DLYW), .LENW(LENW)) dut (
    .CLK        (clk),
    .RST        (rst),
    .WR_DATA    (wr_data),
    .WR_VALID   (wr_valid),
    .WR_READY   (wr_ready),
    .STRB       (strb),
    .STRB_DELAY (strb_delay),
    .BURST_LEN  (burst_len),
    .DQ_IN      (dq_in),
    .DQ_IN_VALID(dq_in_valid),
    .BUSY       (busy),
    .STRB_DROP  (strb_drop),
    .UNDERRUN   (underrun),
    .LEVEL      (level)
  );

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: FIFO contents as a queue, one burst as a window of cycles.
  int               tcur = 0;
  int               busy_end = -1;
  int               slot_first = 0;
  logic [DW-1:0]    q[$];
  logic             exp_valid, exp_drop, exp_und;
  logic [DW-1:0]    exp_dq;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, tcur, got, exp);
    end
  endtask

  // Applies the current cycle's inputs and predicts the outputs of the next cycle.
  task automatic model_step();
    bit slot, full_pre;
    if (rst) begin
      q.delete();
      busy_end   = -1;
      slot_first = 0;
      exp_valid  = 1'b0;
      exp_dq     = '0;
      exp_drop   = 1'b0;
      exp_und    = 1'b0;
    end else begin
      exp_drop = 1'b0;
      if (strb) begin
        if (tcur <= busy_end) begin
          exp_drop = 1'b1;
        end else begin
          slot_first = tcur + 1 + int'(strb_delay);
          busy_end   = tcur + int'(strb_delay) + int'(burst_len) + 1;
          $display("burst cycle=%0d delay=%0d words=%0d level=%0d",
                   tcur, strb_delay, int'(burst_len) + 1, q.size());
        end
      end
      full_pre  = (q.size() == DEPTH);
      slot      = (tcur + 1 >= slot_first) && (tcur + 1 <= busy_end);
      exp_valid = 1'b0;
      exp_dq    = '0;
      if (slot) begin
        if (q.size() > 0) begin
          exp_valid = 1'b1;
          exp_dq    = q.pop_front();
        end else begin
          exp_und = 1'b1;
        end
      end
      if (wr_valid && !full_pre) q.push_back(wr_data);
    end
    tcur++;
  endtask

  task automatic check_all();
    check_eq("dq_in_valid", 32'(dq_in_valid), 32'(exp_valid));
    check_eq("dq_in",       32'(dq_in),       32'(exp_dq));
    check_eq("busy",        32'(busy),        32'(tcur <= busy_end));
    check_eq("strb_drop",   32'(strb_drop),   32'(exp_drop));
    check_eq("underrun",    32'(underrun),    32'(exp_und));
    check_eq("level",       32'(level),       32'(q.size()));
    check_eq("wr_ready",    32'(wr_ready),    32'(q.size() != DEPTH));
  endtask

  task automatic pick_inputs(input int t);
    int phase, p_push, p_strb, r;
    phase = (t / 400) % 4;
    case (phase)
      0:       begin p_push = 50; p_strb = 5;  end
      1:       begin p_push = 90; p_strb = 2;  end
      2:       begin p_push = 10; p_strb = 10; end
      default: begin p_push = 60; p_strb = 20; end
    endcase
    rst        = ((t % 700) < 2 && t >= 700) || ($urandom_range(0, 499) == 0);
    wr_valid   = ($urandom_range(0, 99) < p_push);
    wr_data    = DW'($urandom_range(0, 255));
    strb       = ($urandom_range(0, 99) < p_strb);
    burst_len  = LENW'($urandom_range(0, 15));
    r          = $urandom_range(0, 99);
    if (r < 25)      strb_delay = '0;
    else if (r < 35) strb_delay = '1;
    else             strb_delay = DLYW'($urandom_range(0, 7));
  endtask

  initial begin
    rst        = 1'b1;
    wr_valid   = 1'b0;
    wr_data    = '0;
    strb       = 1'b0;
    strb_delay = '0;
    burst_len  = '0;
    model_step();
    for (int t = 1; t < NCYC; t++) begin
      @(negedge clk);
      check_all();
      pick_inputs(t);
      if (t < 3) rst = 1'b1;
      model_step();
    end
    @(negedge clk);
    check_all();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
